router_fifo_eject_bridge: RTL and testbench

// - Ejection-side bridge: router local output -> noc2dla write FIFO.
// - Reassembles HEAD/BODY/TAIL (or HEADTAIL) flits into one staged packet.
// - Rebuilds the header word with the len field, then drains header + payload words into the FIFO.
// - Sits between the router local port and the DLA-side write FIFO; complements the injection bridge.

---
 rtl/router_fifo_eject_bridge.sv | 273 +++++++++++++++++++++++++++
 tb/tb_router_fifo_eject_bridge.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_eject_bridge.sv
// Ejection bridge: reassembles router flits into a staged packet and drains header + payload into the noc2dla write FIFO.
// Optional protocol-error counter is built only when EJECT_ERR_CNT_EN is defined.

package router_fifo_eject_bridge_pkg;
    localparam int VC_NUM         = 4;
    localparam int VC_W           = 2;
    localparam int FLIT_DATA_SIZE = 32;

    localparam logic [1:0] HEAD     = 2'b00;
    localparam logic [1:0] BODY     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    typedef struct packed {
        logic [1:0]                flit_type;
        logic [VC_W-1:0]           vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;
endpackage

module router_fifo_eject_bridge
    import router_fifo_eject_bridge_pkg::*;
#(
    parameter int MAX_PKT_LEN  = 16,
    parameter int ONOFF_MARGIN = 2
) (
    input  logic                      clk_router,
    input  logic                      rst_router,
    input  flit_t                     router_data_out,
    input  logic                      router_valid_out,
    output logic [VC_NUM-1:0]         router_is_on_off_in,
    output logic [VC_NUM-1:0]         router_is_allocatable_in,
    input  logic                      noc2dla_fifo_afull,
    output logic                      noc2dla_fifo_wen,
    output logic [FLIT_DATA_SIZE-1:0] noc2dla_fifo_wdata,
    output logic [7:0]                eject_err_cnt
);

    localparam int F     = FLIT_DATA_SIZE;
    localparam int CNT_W = $clog2(MAX_PKT_LEN + 1);
    localparam int AW    = $clog2(MAX_PKT_LEN);
    localparam int PL_W  = F - 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  ptr_q, ptr_d;
    logic [VC_W-1:0]   vc_q, vc_d;
    logic [3:0]        x_q, x_d;
    logic [3:0]        y_q, y_d;
    logic [2:0]        l_q, l_d;
    logic [PL_W-1:0]   pl_q, pl_d;
    logic              wen_q, wen_d;
    logic [F-1:0]      wdata_q, wdata_d;
    logic [VC_NUM-1:0] on_off_q, on_off_d;
    logic [VC_NUM-1:0] alloc_q, alloc_d;

    logic [F-1:0]      stage_q [MAX_PKT_LEN];
    logic              stage_we_s;
    logic [AW-1:0]     rd_idx_s;
    logic [F-1:0]      hdr_word_s;
    logic              latch_s;
    logic              err_s;
    logic              off_s;

    assign rd_idx_s   = AW'(ptr_q - CNT_W'(1));
    assign hdr_word_s = {x_q, y_q, l_q, 8'(len_q), pl_q};

    // Next-state, staging and drain logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        vc_d       = vc_q;
        x_d        = x_q;
        y_d        = y_q;
        l_d        = l_q;
        pl_d       = pl_q;
        wen_d      = 1'b0;
        wdata_d    = wdata_q;
        stage_we_s = 1'b0;
        latch_s    = 1'b0;
        err_s      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (router_valid_out) begin
                    case (router_data_out.flit_type)
                        HEAD: begin
                            latch_s = 1'b1;
                            cnt_d   = '0;
                            state_d = ST_COLLECT;
                        end
                        HEADTAIL: begin
                            latch_s = 1'b1;
                            len_d   = '0;
                            ptr_d   = '0;
                            state_d = ST_DRAIN;
                        end
                        default: err_s = 1'b1;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COLLECT: begin
                if (!router_valid_out) begin
                    state_d = ST_COLLECT;
                end else if (router_data_out.vc_id != vc_q) begin
                    err_s = 1'b1;
                end else begin
                    case (router_data_out.flit_type)
                        HEAD: begin
                            // A fresh head abandons the partial packet
                            latch_s = 1'b1;
                            cnt_d   = '0;
                            err_s   = 1'b1;
                        end
                        HEADTAIL: begin
                            latch_s = 1'b1;
                            len_d   = '0;
                            ptr_d   = '0;
                            err_s   = 1'b1;
                            state_d = ST_DRAIN;
                        end
                        BODY: begin
                            if (cnt_q < CNT_W'(MAX_PKT_LEN)) begin
                                stage_we_s = 1'b1;
                                cnt_d      = cnt_q + CNT_W'(1);
                            end else begin
                                err_s = 1'b1;
                            end
                        end
                        TAIL: begin
                            if (cnt_q < CNT_W'(MAX_PKT_LEN)) begin
                                stage_we_s = 1'b1;
                                cnt_d      = cnt_q + CNT_W'(1);
                                len_d      = cnt_q + CNT_W'(1);
                            end else begin
                                err_s = 1'b1;
                                len_d = cnt_q;
                            end
                            ptr_d   = '0;
                            state_d = ST_DRAIN;
                        end
                        default: err_s = 1'b1;
                    endcase
                end
            end

            ST_DRAIN: begin
                err_s = router_valid_out;
                // ptr 0 is the header, ptr k>0 is stage[k-1]
                if (!noc2dla_fifo_afull) begin
                    wen_d   = 1'b1;
                    wdata_d = (ptr_q == '0) ? hdr_word_s : stage_q[rd_idx_s];
                    if (ptr_q == len_q) begin
                        ptr_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        ptr_d = ptr_q + CNT_W'(1);
                    end
                end else begin
                    wen_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (latch_s) begin
            vc_d = router_data_out.vc_id;
            x_d  = router_data_out.data[F-1 -: 4];
            y_d  = router_data_out.data[F-5 -: 4];
            l_d  = router_data_out.data[F-9 -: 3];
            pl_d = router_data_out.data[PL_W-1:0];
        end else begin
            vc_d = vc_d;
        end
    end

    // Flow-control outputs derived from where the FSM is heading
    always_comb begin
        off_s = (state_d == ST_DRAIN) || noc2dla_fifo_afull ||
                ((state_d == ST_COLLECT) && (cnt_d >= CNT_W'(MAX_PKT_LEN - ONOFF_MARGIN)));
        on_off_d = {VC_NUM{~off_s}};
        alloc_d  = {VC_NUM{state_d == ST_IDLE}};
    end

    // Control and output registers
    always_ff @(posedge clk_router) begin
        if (rst_router) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            ptr_q    <= '0;
            vc_q     <= '0;
            x_q      <= 4'd0;
            y_q      <= 4'd0;
            l_q      <= 3'd0;
            pl_q     <= '0;
            wen_q    <= 1'b0;
            wdata_q  <= '0;
            on_off_q <= '1;
            alloc_q  <= '1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            ptr_q    <= ptr_d;
            vc_q     <= vc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            l_q      <= l_d;
            pl_q     <= pl_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            on_off_q <= on_off_d;
            alloc_q  <= alloc_d;
        end
    end

    // Staging RAM; contents are don't-care until written for the current packet
    always_ff @(posedge clk_router) begin
        if (stage_we_s && !rst_router) begin
            stage_q[AW'(cnt_q)] <= router_data_out.data;
        end
    end

    assign noc2dla_fifo_wen         = wen_q;
    assign noc2dla_fifo_wdata       = wdata_q;
    assign router_is_on_off_in      = on_off_q;
    assign router_is_allocatable_in = alloc_q;

`ifdef EJECT_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Saturating error counter
    always_comb begin
        if (err_s && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register
    always_ff @(posedge clk_router) begin
        if (rst_router) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign eject_err_cnt = err_cnt_q;
`else
    logic err_unused_s;
    assign err_unused_s  = err_s;
    assign eject_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_router_fifo_eject_bridge.sv
// Directed self-checking bench for router_fifo_eject_bridge (honours EJECT_ERR_CNT_EN for the error counter).

module tb_router_fifo_eject_bridge;
    import router_fifo_eject_bridge_pkg::*;

    logic        clk;
    logic        rst;
    flit_t       fl;
    logic        valid;
    logic [3:0]  on_off;
    logic [3:0]  alloc;
    logic        afull;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  err_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] words[$];
    int first_w, last_w, nw;

`ifdef EJECT_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    router_fifo_eject_bridge #(.MAX_PKT_LEN(16), .ONOFF_MARGIN(2)) dut (
        .clk_router               (clk),
        .rst_router               (rst),
        .router_data_out          (fl),
        .router_valid_out         (valid),
        .router_is_on_off_in      (on_off),
        .router_is_allocatable_in (alloc),
        .noc2dla_fifo_afull       (afull),
        .noc2dla_fifo_wen         (wen),
        .noc2dla_fifo_wdata       (wdata),
        .eject_err_cnt            (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hdr(input logic [3:0] x, input logic [3:0] y, input logic [2:0] l,
                                        input logic [7:0] len, input logic [12:0] pl);
        return {x, y, l, len, pl};
    endfunction

    function automatic logic [7:0] exp_err(input int n);
        return ERR_EN ? 8'(n) : 8'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] t, input logic [1:0] vc, input logic [31:0] d);
        fl.flit_type = t;
        fl.vc_id     = vc;
        fl.data      = d;
        valid        = 1'b1;
        tick();
        valid        = 1'b0;
    endtask

    // n cycles of drain observation; afull held on ticks [af_lo..af_hi]; a HEAD injected on tick inj
    task automatic collect(input int n, input int af_lo, input int af_hi, input int inj);
        words.delete();
        first_w = -1;
        last_w  = -1;
        nw      = 0;
        for (int i = 1; i <= n; i++) begin
            afull = (i >= af_lo) && (i <= af_hi);
            if (i == inj) begin
                fl.flit_type = HEAD;
                fl.data      = 32'hFFFF_FFFF;
                valid        = 1'b1;
            end
            tick();
            valid = 1'b0;
            if (wen === 1'b1) begin
                words.push_back(wdata);
                if (first_w < 0) first_w = i;
                last_w = i;
                nw++;
            end
        end
        afull = 1'b0;
    endtask

    function automatic logic [31:0] word_at(input int k);
        return (k < words.size()) ? words[k] : 32'hxxxx_xxxx;
    endfunction

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        afull = 1'b0;
        fl    = '0;
        tick();
        tick();
        check("rst_wen",    64'(wen),     64'd0);
        check("rst_wdata",  64'(wdata),   64'd0);
        check("rst_onoff",  64'(on_off),  64'hF);
        check("rst_alloc",  64'(alloc),   64'hF);
        check("rst_errcnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        tick();

        // Basic 4-word packet
        send(HEAD, 2'd1, hdr(4'd3, 4'd2, 3'd1, 8'hFF, 13'h5A));
        check("t1_alloc_after_head", 64'(alloc), 64'h0);
        check("t1_onoff_collect",    64'(on_off), 64'hF);
        send(BODY, 2'd1, 32'hA000_0001);
        send(BODY, 2'd1, 32'hA000_0002);
        send(BODY, 2'd1, 32'hA000_0003);
        send(TAIL, 2'd1, 32'hA000_0004);
        check("t1_onoff_drain", 64'(on_off), 64'h0);
        collect(7, 0, -1, 0);
        check("t1_nw",    64'(nw),      64'd5);
        check("t1_first", 64'(first_w), 64'd1);
        check("t1_last",  64'(last_w),  64'd5);
        check("t1_hdr",   64'(word_at(0)), 64'(hdr(4'd3, 4'd2, 3'd1, 8'd4, 13'h5A)));
        check("t1_w0",    64'(word_at(1)), 64'hA000_0001);
        check("t1_w1",    64'(word_at(2)), 64'hA000_0002);
        check("t1_w2",    64'(word_at(3)), 64'hA000_0003);
        check("t1_w3",    64'(word_at(4)), 64'hA000_0004);
        check("t1_alloc_idle", 64'(alloc), 64'hF);

        // HEADTAIL
        send(HEADTAIL, 2'd0, hdr(4'd1, 4'd1, 3'd0, 8'hFF, 13'h1234));
        collect(3, 0, -1, 0);
        check("t2_nw",    64'(nw),      64'd1);
        check("t2_first", 64'(first_w), 64'd1);
        check("t2_hdr",   64'(word_at(0)), 64'(hdr(4'd1, 4'd1, 3'd0, 8'd0, 13'h1234)));
        check("t2_alloc", 64'(alloc), 64'hF);

        // afull stall during 2nd data word
        send(HEAD, 2'd1, hdr(4'd3, 4'd2, 3'd1, 8'h00, 13'h5A));
        send(BODY, 2'd1, 32'hB000_0001);
        send(BODY, 2'd1, 32'hB000_0002);
        send(BODY, 2'd1, 32'hB000_0003);
        send(TAIL, 2'd1, 32'hB000_0004);
        collect(10, 3, 5, 0);
        check("t3_nw",    64'(nw),      64'd5);
        check("t3_first", 64'(first_w), 64'd1);
        check("t3_last",  64'(last_w),  64'd8);
        check("t3_hdr",   64'(word_at(0)), 64'(hdr(4'd3, 4'd2, 3'd1, 8'd4, 13'h5A)));
        check("t3_w0",    64'(word_at(1)), 64'hB000_0001);
        check("t3_w1",    64'(word_at(2)), 64'hB000_0002);
        check("t3_w2",    64'(word_at(3)), 64'hB000_0003);
        check("t3_w3",    64'(word_at(4)), 64'hB000_0004);
        check("t3_errcnt", 64'(err_cnt), 64'd0);

        // Overlong packet: 20 BODY + TAIL
        send(HEAD, 2'd3, hdr(4'd7, 4'd4, 3'd5, 8'h00, 13'h0123));
        for (int i = 0; i < 20; i++) begin
            send(BODY, 2'd3, 32'h1000 + 32'(i));
            if (i == 12) check("t4_onoff_cnt13", 64'(on_off), 64'hF);
            if (i == 13) check("t4_onoff_cnt14", 64'(on_off), 64'h0);
        end
        send(TAIL, 2'd3, 32'hDEAD_BEEF);
        collect(20, 0, -1, 0);
        check("t4_nw",   64'(nw),     64'd17);
        check("t4_last", 64'(last_w), 64'd17);
        check("t4_hdr",  64'(word_at(0)), 64'(hdr(4'd7, 4'd4, 3'd5, 8'd16, 13'h0123)));
        check("t4_w0",   64'(word_at(1)),  64'h1000);
        check("t4_w7",   64'(word_at(8)),  64'h1007);
        check("t4_w15",  64'(word_at(16)), 64'h100F);
        check("t4_errcnt", 64'(err_cnt), 64'(exp_err(5)));

        // Protocol errors, then an intact packet; HEAD at last drain write is dropped
        send(BODY, 2'd2, 32'hEEEE_0000);
        send(HEAD, 2'd2, hdr(4'd9, 4'd8, 3'd7, 8'h00, 13'h0AAA));
        send(BODY, 2'd3, 32'hEEEE_0001);
        send(BODY, 2'd2, 32'hEEEE_0002);
        send(HEAD, 2'd2, hdr(4'd2, 4'd5, 3'd3, 8'h00, 13'h0777));
        send(BODY, 2'd2, 32'hC000_0001);
        send(BODY, 2'd2, 32'hC000_0002);
        send(TAIL, 2'd2, 32'hC000_0003);
        check("t5_errcnt_pre", 64'(err_cnt), 64'(exp_err(8)));
        collect(6, 0, -1, 4);
        check("t5_nw",   64'(nw),     64'd4);
        check("t5_last", 64'(last_w), 64'd4);
        check("t5_hdr",  64'(word_at(0)), 64'(hdr(4'd2, 4'd5, 3'd3, 8'd3, 13'h0777)));
        check("t5_w0",   64'(word_at(1)), 64'hC000_0001);
        check("t5_w1",   64'(word_at(2)), 64'hC000_0002);
        check("t5_w2",   64'(word_at(3)), 64'hC000_0003);
        check("t5_errcnt", 64'(err_cnt), 64'(exp_err(9)));
        check("t5_alloc",  64'(alloc),   64'hF);

        // Reset mid-packet at cnt=2
        send(HEAD, 2'd0, hdr(4'd4, 4'd4, 3'd4, 8'h00, 13'h0044));
        send(BODY, 2'd0, 32'hD000_0001);
        send(BODY, 2'd0, 32'hD000_0002);
        rst = 1'b1;
        tick();
        check("t6_rst_wen",    64'(wen),     64'd0);
        check("t6_rst_wdata",  64'(wdata),   64'd0);
        check("t6_rst_onoff",  64'(on_off),  64'hF);
        check("t6_rst_alloc",  64'(alloc),   64'hF);
        check("t6_rst_errcnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        collect(4, 0, -1, 0);
        check("t6_no_writes", 64'(nw), 64'd0);
        send(HEAD, 2'd1, hdr(4'd6, 4'd3, 3'd2, 8'h00, 13'h0066));
        send(BODY, 2'd1, 32'hF000_0001);
        send(TAIL, 2'd1, 32'hF000_0002);
        collect(6, 0, -1, 0);
        check("t6_nw",  64'(nw), 64'd3);
        check("t6_hdr", 64'(word_at(0)), 64'(hdr(4'd6, 4'd3, 3'd2, 8'd2, 13'h0066)));
        check("t6_w0",  64'(word_at(1)), 64'hF000_0001);
        check("t6_w1",  64'(word_at(2)), 64'hF000_0002);
        check("t6_errcnt", 64'(err_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
